// File: rtl/mac_accum.sv
// mac_accum: sums VEC_LEN signed samples per vector into a handshaked result register.
// Define MAC_ACCUM_SAT_EN to clamp each addition instead of wrapping.
module mac_accum #(
    parameter int IN_WIDTH  = 40,
    parameter int ACC_WIDTH = 48,
    parameter int VEC_LEN   = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [IN_WIDTH-1:0]          i_val,
    input  logic                         i_valid,
    input  logic                         i_clear,
    input  logic                         i_ready,
    output logic [ACC_WIDTH-1:0]         o_sum,
    output logic                         o_valid,
    output logic                         o_sat,
    output logic                         o_overrun,
    output logic [$clog2(VEC_LEN+1)-1:0] o_count
);

    localparam int CW = $clog2(VEC_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]                  state;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] ext;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic                        acc_sat;
    logic                        ovf;
    logic                        accept;
    logic                        done;

    assign ext    = ACC_WIDTH'($signed(i_val));
    assign base   = (o_count == '0) ? '0 : acc;
    assign accept = i_valid & ~i_clear;
    assign done   = accept && (o_count == LAST);

`ifdef MAC_ACCUM_SAT_EN
    localparam logic [ACC_WIDTH-1:0] MAX_V = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] MIN_V = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH:0] wide;

    // One guard bit: overflow when it disagrees with the result sign.
    always_comb begin
        wide = {base[ACC_WIDTH-1], base} + {ext[ACC_WIDTH-1], ext};
        ovf  = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
        if (!ovf) begin
            acc_next = wide[ACC_WIDTH-1:0];
        end else if (wide[ACC_WIDTH]) begin
            acc_next = MIN_V;
        end else begin
            acc_next = MAX_V;
        end
    end
`else
    assign acc_next = base + ext;
    assign ovf      = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc     <= '0;
            acc_sat <= 1'b0;
            o_count <= '0;
            o_sum   <= '0;
            o_sat   <= 1'b0;
        end else if (i_clear) begin
            o_count <= '0;
            acc_sat <= 1'b0;
        end else if (i_valid) begin
            if (done) begin
                o_count <= '0;
                acc_sat <= 1'b0;
                o_sum   <= acc_next;
                o_sat   <= acc_sat | ovf;
            end else begin
                o_count <= o_count + CW'(1);
                acc     <= acc_next;
                acc_sat <= acc_sat | ovf;
            end
        end
    end

    // A completion always wins; a transfer only empties when nothing new lands.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= EMPTY;
            o_overrun <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (done) state <= FULL;
                end
                FULL: begin
                    if (done) begin
                        if (!i_ready) o_overrun <= 1'b1;
                    end else if (i_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign o_valid = (state == FULL);

endmodule
